// File: rtl/syscall_unit.sv
// syscall_unit
//   Multi-cycle responder for the decoder's syscall strobe. Services the
//   SPIM-style calls selected by $v0 (vreg), with $a0 (areg) as argument:
//     4  = print string (NUL-terminated, read through the word read port)
//     11 = print char   (areg[7:0])
//     10 = exit         (sticky halt)
//   Characters leave over a valid/ready handshake. The CPU is stalled until
//   the call completes, then released for exactly one DONE cycle.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   syscall, vreg, areg   decoder strobe (level) and $v0/$a0 values
//   stall                 freezes PC and register writes
//   mem_rd, mem_addr      one-cycle word read request, word-aligned address
//   mem_rdata             read data, valid the cycle after mem_rd
//   char_valid/data/ready console sink handshake
//   halt                  sticky, set by exit
//   err                   one-cycle pulse: unsupported call or truncation
//
// state  | meaning
// IDLE   | waiting for syscall; decodes vreg when it is seen
// FETCH  | word read request at the aligned string pointer
// WAIT   | capture the returned word
// EMIT   | offer the byte under the pointer to the console
// PUTC   | offer the latched print-char byte to the console
// DONE   | one unstalled cycle so the CPU retires the SYSCALL
// HALTED | exit taken; stalled until reset
module syscall_unit #(
  parameter int MAX_LEN    = 256,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] vreg,
  input  logic [31:0] areg,
  output logic        stall,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        halt,
  output logic        err
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] EMIT   = 3'd3;
  localparam logic [2:0] PUTC   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] HALTED = 3'd6;

  logic [2:0]    state, state_nxt;
  logic [31:0]   addr;
  logic [31:0]   addr_inc;
  logic [31:0]   word;
  logic [CW-1:0] cnt;
  logic [7:0]    pchar;
  logic          err_q;
  logic          err_set;
  logic [1:0]    lane;
  logic [7:0]    cur_byte;
  logic          emit_ok;
  logic          xfer;

  // Big-endian puts byte offset 0 in the top lane, so the lane index is
  // the bitwise complement of the offset.
  assign lane     = BIG_ENDIAN ? ~addr[1:0] : addr[1:0];
  assign cur_byte = word[{lane, 3'b000} +: 8];
  assign addr_inc = addr + 32'd1;

  // A byte is offered only when it is neither the terminator nor past the
  // truncation limit.
  assign emit_ok = (state == EMIT) && (cur_byte != 8'h00) && (cnt != CNT_MAX);

  assign char_valid = emit_ok || (state == PUTC);
  assign char_data  = (state == PUTC) ? pchar :
                      emit_ok         ? cur_byte : 8'h00;
  assign xfer       = char_valid && char_ready;

  assign mem_rd   = (state == FETCH);
  assign mem_addr = (state == FETCH) ? {addr[31:2], 2'b00} : 32'h0000_0000;

  // The syscall cycle itself is stalled, hence the combinational IDLE term.
  assign stall = ((state == IDLE) && syscall) ||
                 (state == FETCH) || (state == WAIT) || (state == EMIT) ||
                 (state == PUTC)  || (state == HALTED);

  assign halt = (state == HALTED);
  assign err  = err_q;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (syscall) begin
          case (vreg)
            32'd4:   state_nxt = FETCH;
            32'd11:  state_nxt = PUTC;
            32'd10:  state_nxt = HALTED;
            default: begin
              state_nxt = DONE;
              err_set   = 1'b1;
            end
          endcase
        end
      end
      FETCH: state_nxt = WAIT;
      WAIT:  state_nxt = EMIT;
      EMIT: begin
        if (cur_byte == 8'h00) begin
          state_nxt = DONE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end else if (char_ready && (addr_inc[1:0] == 2'b00)) begin
          // Pointer crossed into the next word: it must be fetched first.
          state_nxt = FETCH;
        end
      end
      PUTC: begin
        if (char_ready) state_nxt = DONE;
      end
      DONE:   state_nxt = IDLE;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr  <= 32'h0000_0000;
      word  <= 32'h0000_0000;
      cnt   <= '0;
      pchar <= 8'h00;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      case (state)
        IDLE: begin
          if (syscall && (vreg == 32'd4)) begin
            addr <= areg;
            cnt  <= '0;
          end
          if (syscall && (vreg == 32'd11)) begin
            pchar <= areg[7:0];
          end
        end
        WAIT: word <= mem_rdata;
        EMIT: begin
          if (xfer) begin
            addr <= addr_inc;
            cnt  <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall;
  logic        sel;
  logic [31:0] vreg, areg;
  logic        char_ready;

  logic        sc0, sc1;
  logic        stall0, stall1, mem_rd0, mem_rd1, cv0, cv1, halt0, halt1, err0, err1;
  logic [31:0] mem_addr0, mem_addr1, rdata0, rdata1;
  logic [7:0]  cd0, cd1;

  logic        o_stall, o_mem_rd, o_cv, o_halt, o_err;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_cd;

  logic [7:0]  mem [0:2047];

  int          n_checks = 0;
  int          n_fail   = 0;

  // Per-call observations
  int          stall_hi, errs, cvs, rd_n, ch_n;
  logic [31:0] rd_log [0:7];
  logic [7:0]  ch_log [0:15];
  logic        unstable, timed_out;

  always #5 clk = ~clk;

  assign sc0 = syscall & ~sel;
  assign sc1 = syscall & sel;

  assign o_stall    = sel ? stall1    : stall0;
  assign o_mem_rd   = sel ? mem_rd1   : mem_rd0;
  assign o_mem_addr = sel ? mem_addr1 : mem_addr0;
  assign o_cv       = sel ? cv1       : cv0;
  assign o_cd       = sel ? cd1       : cd0;
  assign o_halt     = sel ? halt1     : halt0;
  assign o_err      = sel ? err1      : err0;

  syscall_unit #(.MAX_LEN(256), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset), .syscall(sc0), .vreg(vreg), .areg(areg),
    .stall(stall0), .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_rdata(rdata0),
    .char_valid(cv0), .char_data(cd0), .char_ready(char_ready),
    .halt(halt0), .err(err0)
  );

  syscall_unit #(.MAX_LEN(4), .BIG_ENDIAN(1'b0)) dut4 (
    .clk(clk), .reset(reset), .syscall(sc1), .vreg(vreg), .areg(areg),
    .stall(stall1), .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
    .char_valid(cv1), .char_data(cd1), .char_ready(char_ready),
    .halt(halt1), .err(err1)
  );

  // Read port models: data valid the cycle after the request.
  always @(posedge clk) begin
    if (mem_rd0)
      rdata0 <= {mem[mem_addr0[10:0]], mem[mem_addr0[10:0] + 11'd1],
                 mem[mem_addr0[10:0] + 11'd2], mem[mem_addr0[10:0] + 11'd3]};
    if (mem_rd1)
      rdata1 <= {mem[mem_addr1[10:0] + 11'd3], mem[mem_addr1[10:0] + 11'd2],
                 mem[mem_addr1[10:0] + 11'd1], mem[mem_addr1[10:0]]};
  end

  // Runs one call on the selected unit until its DONE cycle.
  task automatic do_call(input logic [31:0] v, input logic [31:0] a, input logic toggle);
    logic       hold;
    logic [7:0] held;
    logic       done;
    @(negedge clk);
    syscall = 1'b1; vreg = v; areg = a; char_ready = 1'b1;
    stall_hi = 0; errs = 0; cvs = 0; rd_n = 0; ch_n = 0;
    unstable = 1'b0; timed_out = 1'b0; hold = 1'b0; held = 8'h00; done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      #1;
      if (o_mem_rd && rd_n < 8) begin rd_log[rd_n] = o_mem_addr; rd_n++; end
      if (o_err) errs++;
      if (o_cv) cvs++;
      if (hold && (!o_cv || o_cd != held)) unstable = 1'b1;
      if (o_cv && char_ready && ch_n < 16) begin ch_log[ch_n] = o_cd; ch_n++; end
      hold = o_cv && !char_ready;
      held = o_cd;
      if (!o_stall) begin done = 1'b1; break; end
      stall_hi++;
      @(negedge clk);
      if (toggle) char_ready = ~char_ready;
    end
    syscall = 1'b0;
    char_ready = 1'b1;
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; syscall = 1'b0; sel = 1'b0; vreg = 0; areg = 0; char_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", o_stall); end
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %0b want 0", o_halt); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", o_err); end
    n_checks++; if (o_cv !== 1'b0) begin n_fail++; $display("FAIL reset_char_valid got %0b want 0", o_cv); end
    n_checks++; if (o_cd !== 8'h00) begin n_fail++; $display("FAIL reset_char_data got %h want 00", o_cd); end
    n_checks++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got %0b want 0", o_mem_rd); end
    n_checks++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", o_mem_addr); end
    syscall = 1'b1;
    #1;
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_with_syscall got %0b want 1", o_stall); end
    syscall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_print_aligned();
    sel = 1'b0;
    do_call(32'd4, 32'h100, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL hi_timeout got %0b want 0", timed_out); end
    n_checks++; if (rd_n !== 1) begin n_fail++; $display("FAIL hi_reads got %0d want 1", rd_n); end
    n_checks++; if (rd_log[0] !== 32'h100) begin n_fail++; $display("FAIL hi_read_addr got %h want 00000100", rd_log[0]); end
    n_checks++; if (ch_n !== 2) begin n_fail++; $display("FAIL hi_char_count got %0d want 2", ch_n); end
    n_checks++; if ({ch_log[0], ch_log[1]} !== 16'h4869) begin n_fail++; $display("FAIL hi_chars got %h want 4869", {ch_log[0], ch_log[1]}); end
    n_checks++; if (stall_hi !== 6) begin n_fail++; $display("FAIL hi_stall_cycles got %0d want 6", stall_hi); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL hi_err got %0d want 0", errs); end
  endtask

  task automatic test_unaligned_toggle();
    sel = 1'b0;
    do_call(32'd4, 32'h203, 1'b1);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL unal_timeout got %0b want 0", timed_out); end
    n_checks++; if (rd_n !== 3) begin n_fail++; $display("FAIL unal_reads got %0d want 3", rd_n); end
    n_checks++; if ({rd_log[0], rd_log[1], rd_log[2]} !== {32'h200, 32'h204, 32'h208}) begin
      n_fail++; $display("FAIL unal_read_addrs got %h %h %h want 200 204 208", rd_log[0], rd_log[1], rd_log[2]); end
    n_checks++; if (ch_n !== 5) begin n_fail++; $display("FAIL unal_char_count got %0d want 5", ch_n); end
    n_checks++; if ({ch_log[0], ch_log[1], ch_log[2], ch_log[3], ch_log[4]} !== 40'h4142434445) begin
      n_fail++; $display("FAIL unal_chars got %h want 4142434445", {ch_log[0], ch_log[1], ch_log[2], ch_log[3], ch_log[4]}); end
    n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL unal_hold_stable got %0b want 0", unstable); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL unal_err got %0d want 0", errs); end
  endtask

  task automatic test_word_boundary();
    // 7 chars + NUL fill exactly two words: 1 + 2*2 + 7 + 1 = 13 stalled cycles.
    sel = 1'b0;
    do_call(32'd4, 32'h300, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bnd_timeout got %0b want 0", timed_out); end
    n_checks++; if (stall_hi !== 13) begin n_fail++; $display("FAIL bnd_stall_cycles got %0d want 13", stall_hi); end
    n_checks++; if (rd_n !== 2) begin n_fail++; $display("FAIL bnd_reads got %0d want 2", rd_n); end
    n_checks++; if (ch_n !== 7) begin n_fail++; $display("FAIL bnd_char_count got %0d want 7", ch_n); end
    n_checks++; if ({ch_log[0], ch_log[6]} !== 16'h736C) begin n_fail++; $display("FAIL bnd_first_last got %h want 736c", {ch_log[0], ch_log[6]}); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_call(32'd11, 32'h1234_5641, 1'b0);
    n_checks++; if (ch_n !== 1 || ch_log[0] !== 8'h41) begin n_fail++; $display("FAIL putc_char got n=%0d c=%h want n=1 c=41", ch_n, ch_log[0]); end
    n_checks++; if (stall_hi !== 2) begin n_fail++; $display("FAIL putc_stall_cycles got %0d want 2", stall_hi); end
    n_checks++; if (rd_n !== 0) begin n_fail++; $display("FAIL putc_reads got %0d want 0", rd_n); end
    do_call(32'd7, 32'h0, 1'b0);
    n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL bad_err_pulses got %0d want 1", errs); end
    n_checks++; if (stall_hi !== 1) begin n_fail++; $display("FAIL bad_stall_cycles got %0d want 1", stall_hi); end
    n_checks++; if (cvs !== 0) begin n_fail++; $display("FAIL bad_char_valid got %0d want 0", cvs); end
    @(negedge clk); #1;
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_width got %0b want 0", o_err); end
  endtask

  task automatic test_truncate();
    // Little-endian unit with MAX_LEN=4: "0123" then truncation error.
    sel = 1'b1;
    do_call(32'd4, 32'h400, 1'b0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL trunc_timeout got %0b want 0", timed_out); end
    n_checks++; if (ch_n !== 4) begin n_fail++; $display("FAIL trunc_char_count got %0d want 4", ch_n); end
    n_checks++; if ({ch_log[0], ch_log[1], ch_log[2], ch_log[3]} !== 32'h30313233) begin
      n_fail++; $display("FAIL trunc_chars got %h want 30313233", {ch_log[0], ch_log[1], ch_log[2], ch_log[3]}); end
    n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL trunc_err got %0d want 1", errs); end
    n_checks++; if (stall_hi !== 10) begin n_fail++; $display("FAIL trunc_stall_cycles got %0d want 10", stall_hi); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_string();
    logic seen;
    sel = 1'b0; seen = 1'b0;
    @(negedge clk);
    char_ready = 1'b0; syscall = 1'b1; vreg = 32'd4; areg = 32'h203;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (o_cv) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_seen got %0b want 1", seen); end
    reset = 1'b1; syscall = 1'b0;
    #1;
    n_checks++; if (o_cv !== 1'b0) begin n_fail++; $display("FAIL rstmid_char_valid got %0b want 0", o_cv); end
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %0b want 0", o_stall); end
    n_checks++; if (o_cd !== 8'h00) begin n_fail++; $display("FAIL rstmid_char_data got %h want 00", o_cd); end
    @(negedge clk);
    reset = 1'b0; char_ready = 1'b1;
    do_call(32'd11, 32'h0000_005A, 1'b0);
    n_checks++; if (ch_n !== 1 || ch_log[0] !== 8'h5A) begin n_fail++; $display("FAIL rstmid_after got n=%0d c=%h want n=1 c=5a", ch_n, ch_log[0]); end
  endtask

  task automatic test_halt();
    int bad;
    sel = 1'b0; bad = 0;
    @(negedge clk);
    syscall = 1'b1; vreg = 32'd10; areg = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (!(o_halt === 1'b1 && o_stall === 1'b1)) bad++;
      syscall = ~syscall;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL halt_held got %0d bad cycles want 0", bad); end
    reset = 1'b1; syscall = 1'b0;
    #1;
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL halt_reset_halt got %0b want 0", o_halt); end
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL halt_reset_stall got %0b want 0", o_stall); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL halt_after_reset got %0b want 0", o_halt); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h100] = 8'h48; mem[11'h101] = 8'h69;
    mem[11'h200] = 8'h77; mem[11'h201] = 8'h77; mem[11'h202] = 8'h77;
    for (int i = 0; i < 5; i++) mem[11'h203 + i] = 8'h41 + 8'(i);
    mem[11'h300] = 8'h73; mem[11'h301] = 8'h79; mem[11'h302] = 8'h73; mem[11'h303] = 8'h63;
    mem[11'h304] = 8'h61; mem[11'h305] = 8'h6C; mem[11'h306] = 8'h6C;
    for (int i = 0; i < 10; i++) mem[11'h400 + i] = 8'h30 + 8'(i);

    test_reset();
    test_print_aligned();
    test_unaligned_toggle();
    test_word_boundary();
    test_back_to_back();
    test_truncate();
    test_reset_mid_string();
    test_halt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
